// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and default bit timing.
// Also used by the matching transmitter and its bench.
package uart_pkg;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 87;  // 10 MHz clock, 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Bundles the receiver's serial input and byte-side outputs for benches and wrappers.
// uart_rx itself keeps discrete ports so it drops straight into existing system netlists.
interface uart_rx_if;
  import uart_pkg::*;

  logic              rx_serial;
  logic              rx_dv;
  logic [DATA_W-1:0] rx_byte;
  logic              rx_active;
  logic              rx_error;

  // master: the side driving the line and consuming bytes (transmitter / bench)
  modport master (
    output rx_serial,
    input  rx_dv,
    input  rx_byte,
    input  rx_active,
    input  rx_error
  );

  // slave: the receiver
  modport slave (
    input  rx_serial,
    output rx_dv,
    output rx_byte,
    output rx_active,
    output rx_error
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // NOTE: both flops reset to 1 (idle line) so leaving reset can never fake a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, mid-bit sampling, framing-error pulse, break-safe re-arming.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_RX_Serial,
  output logic              o_RX_DV,
  output logic [DATA_W-1:0] o_RX_Byte,
  output logic              o_RX_Active,
  output logic              o_RX_Error
);

  localparam int              CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic s_rx;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (i_RX_Serial),
    .q_o (s_rx)
  );

  uart_state_e       state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic [DATA_W-1:0] byte_q,    byte_d;
  logic              armed_q,   armed_d;
  logic              dv_q,      dv_d;
  logic              err_q,     err_d;

  // NOTE: sequential state is only ever written with non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      byte_q    <= '0;
      armed_q   <= 1'b0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      byte_q    <= byte_d;
      armed_q   <= armed_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
    end
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    byte_d    = byte_q;
    armed_d   = armed_q;
    dv_d      = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && !s_rx) begin
          // The detection cycle is cycle 0, so START begins counting at 1.
          state_d   = START;
          cnt_d     = ONE;
          bit_idx_d = '0;
          armed_d   = 1'b0;
        end else if (s_rx) begin
          armed_d = 1'b1;
        end
      end

      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (s_rx) begin
            state_d = IDLE;
            armed_d = 1'b1;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d             = '0;
          data_d[bit_idx_q] = s_rx;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          // A low stop bit is a break candidate: stay disarmed until the line goes high.
          armed_d = s_rx;
          if (s_rx) begin
            dv_d   = 1'b1;
            byte_d = data_q;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      CLEANUP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_RX_Active = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    o_RX_DV     = dv_q;
    o_RX_Error  = err_q;
    o_RX_Byte   = byte_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frame outcomes, a monitor checks them.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 8;
  localparam int H   = (CPB - 1) / 2;
  // Raw line edge to output pulse: 2 synchronizer cycles + stop sample point + 1.
  localparam int LAT = 2 + H + 9 * CPB + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_RX_Serial (bus.rx_serial),
    .o_RX_DV     (bus.rx_dv),
    .o_RX_Byte   (bus.rx_byte),
    .o_RX_Active (bus.rx_active),
    .o_RX_Error  (bus.rx_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DV or error pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && (bus.rx_dv || bus.rx_error)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {bus.rx_dv, bus.rx_error}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {bus.rx_dv, bus.rx_error}, e.is_err ? 2'b01 : 2'b10);
        check("pulse_cycle", cyc, e.cyc);
        if (e.is_err) begin
          check("byte_held_on_error", bus.rx_byte, last_good);
        end else begin
          check("rx_byte", bus.rx_byte, e.data);
          last_good = e.data;
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    bus.rx_serial = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Reference model: a frame with a high stop bit yields its byte, a low one yields an error.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.is_err = !stop;
    e.data   = d;
    e.cyc    = cyc + LAT;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {bus.rx_dv, bus.rx_error, bus.rx_active, bus.rx_byte}, 11'h000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       saw;
    logic [7:0] d;
    int         gap;

    bus.rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    check("reset_state", dut.state_q, IDLE);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    drive_bit(1'b1);

    // Single good frame, exact DV timing checked by the monitor.
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1);
    wait_drain();
    check("a5_byte_held", bus.rx_byte, 8'hA5);

    // Two-cycle low glitch: a false start that must die at the half-bit check.
    bus.rx_serial = 1'b0;
    repeat (2) @(posedge clk); #1;
    bus.rx_serial = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      saw |= bus.rx_active;
    end
    check("glitch_seen_active", saw, 1'b1);
    check("glitch_active_dropped", bus.rx_active, 1'b0);
    check("glitch_state_idle", dut.state_q, IDLE);
    @(posedge clk); #1;
    drive_bit(1'b1);

    // Framing error followed by a 40-bit break: exactly one error pulse.
    send_frame(8'h3C, 1'b0);
    bus.rx_serial = 1'b0;
    repeat (40 * CPB) @(posedge clk); #1;
    check("break_byte_unchanged", bus.rx_byte, 8'hA5);
    check("break_not_active", bus.rx_active, 1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    wait_drain();

    // Back-to-back frames with zero idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    drive_bit(1'b1);
    wait_drain();

    // Reset in the middle of bit 4 of 8'hC3: the frame is dropped silently.
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    bus.rx_serial = d[4];
    repeat (CPB / 2) @(posedge clk); #1;
    rst = 1'b0;
    bus.rx_serial = 1'b1;
    last_good = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("midframe_reset_outputs");
    end
    check("midframe_reset_state", dut.state_q, IDLE);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    drive_bit(1'b1);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1);
    wait_drain();
    check("after_reset_byte", bus.rx_byte, 8'h81);

    // Loopback-style stream of random bytes with random idle gaps (including none).
    for (int n = 0; n < 256; n++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1);
      gap = $urandom_range(0, 12);
      bus.rx_serial = 1'b1;
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    drive_bit(1'b1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
